// File: rtl/ram_dual_port_sc_if.sv
// ram_dual_port_sc_if: write/read port bundle for the single-clock dual-port RAM
interface ram_dual_port_sc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic                      we;
    logic [ADDR_WIDTH-1:0]     write_addr;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   wbe;
    logic                      re;
    logic [ADDR_WIDTH-1:0]     read_addr;
    logic [DATA_WIDTH-1:0]     q;
    logic                      q_valid;
    logic                      init_done;

    modport master (
        output we, write_addr, data, wbe, re, read_addr,
        input  q, q_valid, init_done
    );

    modport slave (
        input  we, write_addr, data, wbe, re, read_addr,
        output q, q_valid, init_done
    );
endinterface

// File: rtl/ram_dual_port_sc.sv
// ram_dual_port_sc: single-clock simple dual-port RAM with byte enables, RDW policy and post-reset clear sweep
module ram_dual_port_sc #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    RDW_MODE   = 0,
    parameter int                    OUT_REG    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input logic               clk,
    input logic               rst_n,
    ram_dual_port_sc_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {INIT, READY} state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    rdw_hit;
    logic                    s1_v, s2_v, out_v;
    logic [DATA_WIDTH-1:0]   s1_d, s2_d, out_d;

    // controller state and sweep counter; counter freezes once the sweep is over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == INIT) ? cnt + ADDR_WIDTH'(1) : cnt;
        end
    end

    // leave INIT on the edge that clears the last entry
    always_comb state_nx = (state == INIT && &cnt) ? READY : state;

    // user ports are only honoured after the sweep
    always_comb begin
        ready         = (state == READY);
        bus.init_done = ready;
    end

    // array: sweep writes INIT_VALUE, otherwise byte-masked user writes
    always_ff @(posedge clk) begin
        if (!ready)
            mem[cnt] <= INIT_VALUE;
        else if (bus.we)
            for (int i = 0; i < NB; i++)
                if (bus.wbe[i]) mem[bus.write_addr][8*i +: 8] <= bus.data[8*i +: 8];
    end

    // pre-write word, optionally merged with the colliding write bytes
    always_comb begin
        rdw_hit = bus.we && ready && (bus.write_addr == bus.read_addr);
        rd_word = mem[bus.read_addr];
        for (int i = 0; i < NB; i++)
            if (RDW_MODE != 0 && rdw_hit && bus.wbe[i]) rd_word[8*i +: 8] = bus.data[8*i +: 8];
    end

    // pick the last pipeline stage according to the output-register option
    always_comb begin
        out_v = (OUT_REG != 0) ? s2_v : s1_v;
        out_d = (OUT_REG != 0) ? s2_d : s1_d;
    end

    // read pipeline; q only moves when a read completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v        <= 1'b0;
            s1_d        <= '0;
            s2_v        <= 1'b0;
            s2_d        <= '0;
            bus.q       <= '0;
            bus.q_valid <= 1'b0;
        end else begin
            s1_v        <= bus.re && ready;
            if (bus.re && ready) s1_d <= rd_word;
            s2_v        <= s1_v;
            if (s1_v) s2_d <= s1_d;
            bus.q_valid <= out_v;
            if (out_v) bus.q <= out_d;
        end
    end
endmodule

// File: tb/tb_ram_dual_port_sc.sv
// tb_ram_dual_port_sc: random and directed checks of two RAM configurations against a queue-based model
module tb_ram_dual_port_sc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        we = 1'b0, re = 1'b0, chk_on = 1'b0;
    logic [5:0]  wa = '0, ra = '0;
    logic [15:0] d = '0;
    logic [1:0]  be = '0;
    int          total = 0, bad = 0, n, nva, nvb;

    always #5 clk = ~clk;

    ram_dual_port_sc_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(6)) ba ();
    ram_dual_port_sc_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bb ();

    assign ba.we = we;  assign ba.write_addr = wa;  assign ba.data = d[7:0];
    assign ba.wbe = be[0];  assign ba.re = re;  assign ba.read_addr = ra;
    assign bb.we = we;  assign bb.write_addr = wa;  assign bb.data = d;
    assign bb.wbe = be;  assign bb.re = re;  assign bb.read_addr = ra;

    ram_dual_port_sc #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(0), .OUT_REG(1), .INIT_VALUE(8'h00))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ba.slave));
    ram_dual_port_sc #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .RDW_MODE(1), .OUT_REG(0), .INIT_VALUE(16'h5A5A))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bb.slave));

    typedef struct { int due; logic [15:0] val; } ent_t;
    ent_t        pa[$], pb[$];
    logic [15:0] mm [2][64];
    int          cyc = 0, sw = 0;
    logic        exp_v [2];
    logic [15:0] exp_q [2];
    logic        exp_done;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nd, input logic [1:0] en, input int k);
        logic [15:0] r;
        r = old;
        if (en[0]) r[7:0] = nd[7:0];
        if (k == 1 && en[1]) r[15:8] = nd[15:8];
        return r;
    endfunction

    task automatic model_reset();
        pa.delete();
        pb.delete();
        sw = 0;
        exp_done = 1'b0;
        exp_v = '{1'b0, 1'b0};
        exp_q = '{16'h0, 16'h0};
    endtask

    task automatic model_edge(input logic s_we, input logic s_re, input logic [5:0] s_wa, input logic [5:0] s_ra,
                              input logic [15:0] s_d, input logic [1:0] s_be);
        logic rdy;
        logic [15:0] v, wd;
        ent_t e;
        rdy = (sw == 64);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            wd = (k == 0) ? {8'h00, s_d[7:0]} : s_d;
            if (!rdy) mm[k][sw] = (k == 1) ? 16'h5A5A : 16'h0000;
            if (rdy && s_re) begin
                v = mm[k][s_ra];
                if (k == 1 && s_we && s_wa == s_ra) v = merge(v, wd, s_be, k);
                e.due = cyc + ((k == 0) ? 2 : 1);
                e.val = v;
                if (k == 0) pa.push_back(e); else pb.push_back(e);
            end
            if (rdy && s_we) mm[k][s_wa] = merge(mm[k][s_wa], wd, s_be, k);
        end
        if (!rdy) sw++;
        exp_done = (sw == 64);
        exp_v[0] = 1'b0;
        if (pa.size() > 0 && pa[0].due == cyc) begin e = pa.pop_front(); exp_v[0] = 1'b1; exp_q[0] = e.val; end
        exp_v[1] = 1'b0;
        if (pb.size() > 0 && pb[0].due == cyc) begin e = pb.pop_front(); exp_v[1] = 1'b1; exp_q[1] = e.val; end
    endtask

    task automatic tick();
        logic s_we, s_re;
        logic [5:0] s_wa, s_ra;
        logic [15:0] s_d;
        logic [1:0] s_be;
        s_we = we; s_re = re; s_wa = wa; s_ra = ra; s_d = d; s_be = be;
        @(posedge clk);
        if (rst_n) model_edge(s_we, s_re, s_wa, s_ra, s_d, s_be);
        #1;
    endtask

    task automatic hit_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_a_q", 16'(ba.q), 16'h0);
        check("rst_a_v", 16'(ba.q_valid), 16'h0);
        check("rst_b_q", bb.q, 16'h0);
        check("rst_b_v", 16'(bb.q_valid), 16'h0);
    endtask

    task automatic wait_init();
        n = 0;
        while (!ba.init_done && n < 100) begin tick(); n++; end
        check("init_edges", 16'(n), 16'd64);
        check("init_b", 16'(bb.init_done), 16'h1);
    endtask

    // cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("a_valid", 16'(ba.q_valid), 16'(exp_v[0]));
            check("a_q", 16'(ba.q), exp_q[0]);
            check("a_done", 16'(ba.init_done), 16'(exp_done));
            check("b_valid", 16'(bb.q_valid), 16'(exp_v[1]));
            check("b_q", bb.q, exp_q[1]);
            check("b_done", 16'(bb.init_done), 16'(exp_done));
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        model_reset();
        #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", 16'(ba.init_done), 16'h0);
        check("reset_qv", 16'(bb.q_valid), 16'h0);
        #2 rst_n = 1'b1;

        we = 1'b1; wa = 6'h05; d = 16'hAAAA; be = 2'b11; re = 1'b1; ra = 6'h05;
        wait_init();
        we = 1'b0; re = 1'b0;

        nva = 0; nvb = 0;
        for (int a = 0; a < 64; a++) begin
            re = 1'b1; ra = 6'(a);
            tick();
            nva += int'(ba.q_valid); nvb += int'(bb.q_valid);
        end
        re = 1'b0;
        repeat (3) begin tick(); nva += int'(ba.q_valid); nvb += int'(bb.q_valid); end
        check("sweep_cnt_a", 16'(nva), 16'd64);
        check("sweep_cnt_b", 16'(nvb), 16'd64);
        check("sweep_a_q", 16'(ba.q), 16'h00);
        check("sweep_b_q", bb.q, 16'h5A5A);

        we = 1'b1; be = 2'b11; wa = 6'h00; d = 16'h00AA; tick();
        wa = 6'h3F; d = 16'h0055; tick();
        we = 1'b0; re = 1'b1; ra = 6'h00; tick();
        ra = 6'h3F; tick();
        check("lat_b1_v", 16'(bb.q_valid), 16'h1);
        check("lat_b1_q", bb.q, 16'h00AA);
        check("lat_a1_v", 16'(ba.q_valid), 16'h0);
        re = 1'b0; tick();
        check("lat_a2_q", 16'(ba.q), 16'h00AA);
        check("lat_a2_v", 16'(ba.q_valid), 16'h1);
        check("lat_b2_q", bb.q, 16'h0055);
        tick();
        check("lat_a3_q", 16'(ba.q), 16'h0055);
        check("lat_b3_v", 16'(bb.q_valid), 16'h0);

        we = 1'b1; wa = 6'h01; d = 16'h1122; be = 2'b11; tick();
        d = 16'hFFEE; be = 2'b01; tick();
        we = 1'b0; re = 1'b1; ra = 6'h01; tick();
        re = 1'b0; tick();
        check("wbe_b", bb.q, 16'h11EE);
        tick();
        check("wbe_a", 16'(ba.q), 16'h00EE);

        we = 1'b1; wa = 6'h0A; d = 16'h0033; be = 2'b11; tick();
        re = 1'b1; ra = 6'h0A; d = 16'h00FF; tick();
        we = 1'b0; tick();
        check("rdw_new_b", bb.q, 16'h00FF);
        re = 1'b0; tick();
        check("rdw_old_a", 16'(ba.q), 16'h0033);
        check("rdw_next_b", bb.q, 16'h00FF);
        tick();
        check("rdw_next_a", 16'(ba.q), 16'h00FF);

        for (int i = 0; i < 1500; i++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
            d  = 16'($urandom);
            be = 2'($urandom);
            tick();
        end
        we = 1'b0; re = 1'b0;
        repeat (3) tick();

        we = 1'b1; wa = 6'h00; d = 16'h00AA; be = 2'b11; tick();
        we = 1'b0; re = 1'b1; ra = 6'h00; tick();
        re = 1'b0; tick();
        check("pre_rst_b", bb.q, 16'h00AA);
        hit_reset();
        repeat (2) tick();
        #2 rst_n = 1'b1;
        repeat (20) tick();
        check("mid_sweep_done", 16'(ba.init_done), 16'h0);
        hit_reset();
        tick();
        #2 rst_n = 1'b1;
        wait_init();
        re = 1'b1; ra = 6'h00; tick();
        re = 1'b0; tick();
        check("post_b", bb.q, 16'h5A5A);
        tick();
        check("post_a_v", 16'(ba.q_valid), 16'h1);
        check("post_a_q", 16'(ba.q), 16'h00);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
